// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes, widths and speed-curve helper for the dino game
package game_pkg;

  localparam int STATE_W = 3;
  localparam logic [3:0] LEVEL_MAX = 4'd15;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Widened product so a large level*step cannot wrap below the floor.
  function automatic logic [23:0] tick_period(input logic [23:0] base,
                                              input logic [23:0] step,
                                              input logic [23:0] floor_v,
                                              input logic [3:0]  lvl);
    logic [27:0] dec;
    dec = 28'(lvl) * 28'(step);
    if (dec >= {4'd0, base})
      return floor_v;
    else if ((base - dec[23:0]) < floor_v)
      return floor_v;
    else
      return base - dec[23:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, stability filter and rising-edge pulse
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_in,
  output logic pulse
);

  logic        sync1;
  logic        sync2;
  logic        stable;
  logic [19:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= 20'd0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= 20'd0;
      end else if (cnt == DEBOUNCE_CYC) begin
        // Only an accepted press pulses; an accepted release is silent.
        stable <= sync2;
        cnt    <= 20'd0;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - dino game run controller: FSM, shift tick, level and pause timeout
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [23:0] TICK_BASE     = 24'd5_000_000,
  parameter logic [23:0] TICK_STEP     = 24'd250_000,
  parameter logic [23:0] TICK_MIN      = 24'd1_000_000,
  parameter logic [15:0] LEVEL_PTS     = 16'd50,
  parameter logic [19:0] DEBOUNCE_CYC  = 20'd500_000,
  parameter logic [31:0] PAUSE_TIMEOUT = 32'd500_000_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               btn_start,
  input  logic               btn_jump,
  input  logic               btn_pause,
  input  logic               game_over,
  output logic               shift_enable,
  output logic               jump_trigger,
  output logic               start_game,
  output logic               force_game_over,
  output logic [STATE_W-1:0] state,
  output logic [3:0]         level
);

  logic        start_p, jump_p, pause_p;
  state_t      st_q, st_d;
  logic [23:0] tick_q;
  logic [15:0] shift_cnt_q;
  logic [31:0] pause_cnt_q;
  logic        jump_pend_q;
  logic        do_shift, do_force, run_tick;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
    .CLK(CLK), .RST_N(RST_N), .btn_in(btn_start), .pulse(start_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_jump (
    .CLK(CLK), .RST_N(RST_N), .btn_in(btn_jump), .pulse(jump_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
    .CLK(CLK), .RST_N(RST_N), .btn_in(btn_pause), .pulse(pause_p));

  assign state = st_q;

  always_comb begin
    st_d     = st_q;
    do_shift = 1'b0;
    do_force = 1'b0;
    run_tick = 1'b0;
    case (st_q)
      ST_IDLE:  if (start_p) st_d = ST_START;
      ST_START: st_d = ST_RUN;
      ST_RUN: begin
        if (game_over)           st_d = ST_OVER;
        else if (pause_p)        st_d = ST_PAUSE;
        else if (tick_q == 24'd0) do_shift = 1'b1;
        else                     run_tick = 1'b1;
      end
      ST_PAUSE: begin
        if (game_over)                                   st_d = ST_OVER;
        else if (start_p)                                st_d = ST_START;
        else if (pause_p)                                st_d = ST_RUN;
        else if (pause_cnt_q == PAUSE_TIMEOUT - 32'd1) begin
          do_force = 1'b1;
          st_d     = ST_OVER;
        end
      end
      ST_OVER:  if (start_p) st_d = ST_START;
      default:  st_d = ST_IDLE;
    endcase
  end

  // The START cycle itself counts as the first tick, so the first shift lands TICK_BASE after start_game.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q            <= ST_IDLE;
      tick_q          <= 24'd0;
      shift_cnt_q     <= 16'd0;
      pause_cnt_q     <= 32'd0;
      jump_pend_q     <= 1'b0;
      level           <= 4'd0;
      shift_enable    <= 1'b0;
      jump_trigger    <= 1'b0;
      start_game      <= 1'b0;
      force_game_over <= 1'b0;
    end else begin
      st_q            <= st_d;
      start_game      <= (st_d == ST_START);
      shift_enable    <= do_shift;
      jump_trigger    <= do_shift & (jump_pend_q | jump_p);
      force_game_over <= do_force;
      pause_cnt_q     <= (st_q == ST_PAUSE) ? pause_cnt_q + 32'd1 : 32'd0;

      if (st_d == ST_START) begin
        tick_q      <= TICK_BASE - 24'd1;
        level       <= 4'd0;
        shift_cnt_q <= 16'd0;
        jump_pend_q <= 1'b0;
      end else if (st_q == ST_START) begin
        tick_q <= tick_q - 24'd1;
      end else if (do_shift) begin
        tick_q      <= tick_period(TICK_BASE, TICK_STEP, TICK_MIN, level) - 24'd1;
        jump_pend_q <= 1'b0;
        if (shift_cnt_q == LEVEL_PTS - 16'd1) begin
          shift_cnt_q <= 16'd0;
          if (level != LEVEL_MAX) level <= level + 4'd1;
        end else begin
          shift_cnt_q <= shift_cnt_q + 16'd1;
        end
      end else begin
        if (run_tick) tick_q <= tick_q - 24'd1;
        if (st_q == ST_RUN && jump_p) jump_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       btn_start, btn_jump, btn_pause, game_over;
  logic       shift_enable, jump_trigger, start_game, force_game_over;
  logic [2:0] state;
  logic [3:0] level;

  int n_cmp = 0;
  int n_err = 0;
  int stray_jt = 0;
  int gap;
  int cnt;
  int shifts;
  int exp_lvl;
  int exp_gap;

  always #5 CLK = ~CLK;

  game_sequencer #(
    .TICK_BASE(24'd10), .TICK_STEP(24'd2), .TICK_MIN(24'd4),
    .LEVEL_PTS(16'd3), .DEBOUNCE_CYC(20'd4), .PAUSE_TIMEOUT(32'd50)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .btn_start(btn_start), .btn_jump(btn_jump), .btn_pause(btn_pause),
    .game_over(game_over),
    .shift_enable(shift_enable), .jump_trigger(jump_trigger),
    .start_game(start_game), .force_game_over(force_game_over),
    .state(state), .level(level)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_until_shift(output int g);
    g = 0;
    do begin
      step(1);
      g++;
      if (jump_trigger && !shift_enable) stray_jt++;
    end while (!shift_enable && g < 200);
  endtask

  function automatic int exp_period(input int l);
    return (10 - 2 * l < 4) ? 4 : 10 - 2 * l;
  endfunction

  initial begin
    RST_N = 1'b0; btn_start = 1'b0; btn_jump = 1'b0; btn_pause = 1'b0; game_over = 1'b0;
    step(2);
    check("rst_state", 32'(state), 0);
    check("rst_shift", 32'(shift_enable), 0);
    check("rst_start_game", 32'(start_game), 0);
    check("rst_level", 32'(level), 0);
    RST_N = 1'b1;
    step(1);

    // start: start_game 8 cycles after the press, then RUN, first shift 10 after start_game
    btn_start = 1'b1;
    step(7);
    check("idle_before_start", 32'(state), 0);
    step(1);
    check("start_game_pulse", 32'(start_game), 1);
    check("state_start", 32'(state), 1);
    step(1);
    check("state_run", 32'(state), 2);
    check("start_game_once", 32'(start_game), 0);
    btn_start = 1'b0;
    run_until_shift(gap);
    check("first_shift_gap", 32'(gap), 9);
    run_until_shift(gap);
    check("second_shift_gap", 32'(gap), 10);

    // pause with 3 cycles remaining, resume, expect shift 3 cycles into RUN
    btn_pause = 1'b1;
    step(8);
    check("state_pause", 32'(state), 3);
    btn_pause = 1'b0;
    shifts = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (shift_enable) shifts++;
    end
    check("no_shift_paused", 32'(shifts), 0);
    check("still_paused", 32'(state), 3);
    btn_pause = 1'b1;
    step(8);
    check("resume_run", 32'(state), 2);
    btn_pause = 1'b0;
    run_until_shift(gap);
    check("resume_remaining", 32'(gap), 3);
    check("level_after_3", 32'(level), 1);

    // jump mid-period fires on the next shift only
    step(1);
    btn_jump = 1'b1;
    run_until_shift(gap);
    check("jump_shift_gap", 32'(gap), 9);
    check("jump_trigger_set", 32'(jump_trigger), 1);
    btn_jump = 1'b0;
    run_until_shift(gap);
    check("period_level1", 32'(gap), 8);
    check("jump_trigger_clear", 32'(jump_trigger), 0);
    btn_jump = 1'b1;
    step(2);
    btn_jump = 1'b0;
    run_until_shift(gap);
    check("glitch_gap", 32'(gap), 6);
    check("glitch_no_jump", 32'(jump_trigger), 0);
    check("level_after_6", 32'(level), 2);

    // pause timeout forces game over after 50 cycles in PAUSE
    btn_pause = 1'b1;
    step(8);
    check("pause_for_timeout", 32'(state), 3);
    btn_pause = 1'b0;
    cnt = 0;
    shifts = 0;
    do begin
      step(1);
      cnt++;
      if (shift_enable) shifts++;
    end while (!force_game_over && cnt < 100);
    check("timeout_cycles", 32'(cnt), 50);
    check("timeout_no_shift", 32'(shifts), 0);
    check("timeout_state_over", 32'(state), 4);
    step(1);
    check("force_one_cycle", 32'(force_game_over), 0);
    check("over_level_held", 32'(level), 2);

    // restart and walk the speed curve up to saturation
    btn_start = 1'b1;
    step(8);
    check("restart_start_game", 32'(start_game), 1);
    check("restart_level", 32'(level), 0);
    btn_start = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      run_until_shift(gap);
      exp_lvl = (n / 3 > 15) ? 15 : n / 3;
      exp_gap = (n == 1) ? 10 : exp_period(((n - 2) / 3 > 15) ? 15 : (n - 2) / 3);
      check($sformatf("curve_gap_%0d", n), 32'(gap), 32'(exp_gap));
      check($sformatf("curve_level_%0d", n), 32'(level), 32'(exp_lvl));
    end

    // game_over in the tick-expiry cycle suppresses the shift
    step(3);
    game_over = 1'b1;
    step(1);
    check("go_no_shift", 32'(shift_enable), 0);
    check("go_state_over", 32'(state), 4);
    game_over = 1'b0;
    btn_start = 1'b1;
    step(8);
    check("go_restart_pulse", 32'(start_game), 1);
    check("go_restart_level", 32'(level), 0);
    btn_start = 1'b0;
    run_until_shift(gap);
    check("go_restart_period", 32'(gap), 10);

    // asynchronous reset mid-RUN
    step(3);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_outputs", 32'({shift_enable, jump_trigger, start_game, force_game_over}), 0);
    check("arst_level", 32'(level), 0);
    step(2);
    RST_N = 1'b1;
    step(3);
    check("post_reset_idle", 32'(state), 0);
    check("stray_jump_trigger", 32'(stray_jt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level run controller for the dino game. It owns the game state machine, debounces the three player buttons and generates the timed `shift_enable` pulse stream that advances the obstacle/score datapath. It drives `start_game`, `jump_trigger` and `force_game_over` into that datapath and reads back its `game_over` flag. It sits between the board button inputs and the obstacle manager; the display logic reads `state` and `level`.

## Interface
- `TICK_BASE`, 24'd5_000_000: cycles between shifts at level 0.
- `TICK_STEP`, 24'd250_000: period reduction per level.
- `TICK_MIN`, 24'd1_000_000: period floor.
- `LEVEL_PTS`, 16'd50: shifts per level increment.
- `DEBOUNCE_CYC`, 20'd500_000: cycles a synchronized button must be stable before it is accepted.
- `PAUSE_TIMEOUT`, 32'd500_000_000: cycles in PAUSE before a forced game over.
- `CLK`  in  1  system clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `btn_start`, `btn_jump`, `btn_pause`  in  1 each  raw asynchronous buttons, active-high.
- `game_over`  in  1  level from the datapath.
- `shift_enable`  out  1  one-cycle datapath advance pulse.
- `jump_trigger`  out  1  high only in the cycle `shift_enable` is high.
- `start_game`  out  1  one-cycle datapath clear pulse.
- `force_game_over`  out  1  one-cycle pulse.
- `state`  out  3  current FSM state.
- `level`  out  4  speed level, 0..15.

## Operation
- Buttons: each button passes through a 2-flop synchronizer and a stability counter (`DEBOUNCE_CYC`). The accepted level produces a one-cycle rising-edge pulse. Falling edges produce nothing.
- States: IDLE=0, START=1, RUN=2, PAUSE=3, OVER=4. Codes 5–7 return to IDLE on the next cycle.
- IDLE: start pulse goes to START.
- START (exactly one cycle):
  - `start_game`=1.
  - Clear `level`, the shift counter and the jump pending bit.
  - Load the tick counter with `TICK_BASE`-1.
  - Go to RUN.
- RUN: the tick counter decrements each cycle. At 0:
  - `shift_enable`=1.
  - `jump_trigger`=`jump_pend`, then clear `jump_pend`.
  - Reload the tick counter with period(`level`)-1.
  - Increment the shift counter. When it reaches `LEVEL_PTS` it clears, and `level` increments, saturating at 15.
- period(L) = max(`TICK_MIN`, `TICK_BASE` - L·`TICK_STEP`). Compute at 24 bits and clamp, with no underflow. The new level's period applies from the following reload.
- Jump pulse in RUN sets `jump_pend`. Jump pulses in every other state are ignored.
- RUN transitions:
  - `game_over`=1 goes to OVER.
  - Pause pulse goes to PAUSE.
  - Start pulse is ignored.
- PAUSE:
  - Tick counter frozen; `jump_pend` held.
  - Pause pulse goes to RUN, resuming the remaining count.
  - Start pulse goes to START.
  - Pause counter reaching `PAUSE_TIMEOUT`-1 produces `force_game_over`=1 for one cycle and goes to OVER.
- OVER: start pulse goes to START. `level` holds for display.
- Priority within one cycle: `game_over` > start (in PAUSE) > pause > tick.
  - Tick expiry and `game_over` in the same cycle: no `shift_enable`.
  - Jump pulse in the same cycle as tick expiry: `jump_trigger`=1.

## Timing
- Reset (RST_N low, asynchronous): all outputs 0, `state`=IDLE, all counters 0, `jump_pend`=0. Deasserting reset mid-game returns to IDLE; there is no resume.
- All outputs are registered. A state change is visible one cycle after its cause.
- Button to internal pulse: 2 sync cycles + `DEBOUNCE_CYC` + 1.
- First `shift_enable` arrives `TICK_BASE` cycles after the `start_game` cycle. Later pulses are period(`level`) apart.
- The `start_game` pulse and `shift_enable` are never high in the same cycle.
- The pause counter clears when PAUSE is entered.

## Structure
- Shared package `game_pkg` holds the state codes (`ST_IDLE`..`ST_OVER`), the 3-bit state width and the level max (15).
- Sub-module `btn_debounce` (params `DEBOUNCE_CYC`; ports `CLK`, `RST_N`, `btn_in`, `pulse`) is instantiated three times.
- The FSM, tick, level and pause counters all live in the top module.

## Test plan
Bench parameters: `TICK_BASE`=10, `TICK_STEP`=2, `TICK_MIN`=4, `LEVEL_PTS`=3, `DEBOUNCE_CYC`=4, `PAUSE_TIMEOUT`=50.

1. Reset, then start button: `start_game` pulses once and `state` goes 1 then 2. `shift_enable` fires 10 cycles after `start_game`, then every 10.
2. In RUN, after 3 shifts: `level`=1 and the period is 8. After 9 more shifts: `level`=4 and the period is 4. The period stays 4 through `level`=15, and `level` never exceeds 15.
3. Jump pressed mid-period: `jump_trigger`=1 only on the next `shift_enable`, and 0 on the one after. A 2-cycle glitch on `btn_jump` produces no jump.
4. Pause at 3 cycles remaining: no shifts while paused. Pause again: the next `shift_enable` comes 3 cycles after RUN resumes. Pause held 50 cycles: `force_game_over` pulses once and `state`=4.
5. Raise `game_over` in the same cycle the tick counter hits 0: no `shift_enable`, and `state`=4. Start button then produces `start_game`, `level`=0, and the period returns to 10.
6. Pull RST_N low mid-RUN, asynchronously to the clock: all outputs drop to 0 at once and `state`=0.
